mac_frame_streamer: RTL and testbench

//  Parametrised successor to the fixed-width MAC frame generator, used as the TX stimulus agent

---
 rtl/mac_frame_streamer_if.sv | 18 +
 rtl/mac_frame_streamer.sv | 175 +++++++++++++++++
 tb/tb_mac_frame_streamer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_frame_streamer_if.sv
// Word stream from the frame generator towards the line encoder.
// Ports: o_valid/o_data/o_keep/o_sop/o_last from source, i_ready from sink.
// master = frame source, slave = downstream consumer.
interface mac_frame_streamer_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [BYTES-1:0]      o_keep;
  logic                  o_sop;
  logic                  o_last;

  modport master (output o_valid, o_data, o_keep, o_sop, o_last, input i_ready);
  modport slave  (input o_valid, o_data, o_keep, o_sop, o_last, output i_ready);
endinterface

// File: rtl/mac_frame_streamer.sv
// Emits one Ethernet frame (preamble, header, padded payload, FCS) as a word stream.
// Latency: start sampled at edge N, first word valid after edge N+1; done pulse 1 cycle after last accept.
// Backpressure: valid/ready; output word, counter and CRC hold while o_valid && !i_ready.
// Ports: clk, i_rst (async, high); i_start + header fields + length + payload array in;
//        tx (word stream master); o_done / o_error pulses, o_busy level.
module mac_frame_streamer #(
  parameter int DATA_WIDTH       = 64,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int MIN_PAYLOAD      = 46,
  parameter bit INSERT_PREAMBLE  = 1'b1,
  parameter bit APPEND_FCS       = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [47:0] i_dest_address,
  input  logic [47:0] i_src_address,
  input  logic [15:0] i_eth_type,
  input  logic [15:0] i_payload_length,
  input  logic [7:0]  i_payload [PAYLOAD_MAX_SIZE],
  mac_frame_streamer_if.master tx,
  output logic        o_done,
  output logic        o_error,
  output logic        o_busy
);
  localparam int          BYTES    = DATA_WIDTH / 8;
  localparam int          PW       = $clog2(PAYLOAD_MAX_SIZE);
  localparam logic [15:0] BYTES16  = 16'(BYTES);
  localparam logic [15:0] PRE16    = INSERT_PREAMBLE ? 16'd8 : 16'd0;
  localparam logic [15:0] FCS16    = APPEND_FCS ? 16'd4 : 16'd0;
  localparam logic [15:0] MIN16    = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX16    = 16'(PAYLOAD_MAX_SIZE);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;

  logic [111:0]          hdr_q;     // {DA, SA, TYPE}, first-on-wire byte in the top bits
  logic [15:0]           len_q;
  logic [15:0]           cnt_q;     // absolute byte index of the next word to be loaded
  logic [31:0]           crc_q;
  logic                  valid_q, sop_q, last_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BYTES-1:0]      keep_q;

  logic [15:0]           pay_len, data_end, total;
  logic [DATA_WIDTH-1:0] word_d;
  logic [BYTES-1:0]      keep_d;
  logic [31:0]           crc_d;
  logic                  last_d, hs, len_bad;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  assign pay_len  = (len_q < MIN16) ? MIN16 : len_q;
  assign data_end = PRE16 + 16'd14 + pay_len;
  assign total    = data_end + FCS16;
  assign hs       = valid_q && tx.i_ready;
  assign len_bad  = i_payload_length > MAX16;

  assign tx.o_valid = valid_q;
  assign tx.o_data  = data_q;
  assign tx.o_keep  = keep_q;
  assign tx.o_sop   = sop_q;
  assign tx.o_last  = last_q;

  // Build the word at cnt_q lane by lane. The CRC is chained through the data lanes so
  // that FCS bytes sharing the word with the final data bytes see the finished CRC.
  always_comb begin
    logic [15:0] idx, h, p, f;
    logic [7:0]  b;
    logic [31:0] c, fc;
    word_d = '0;
    keep_d = '0;
    c      = crc_q;
    for (int l = 0; l < BYTES; l++) begin
      idx = cnt_q + 16'(l);
      h   = idx - PRE16;
      p   = h - 16'd14;
      f   = idx - data_end;
      fc  = ~c;
      b   = 8'h00;
      if (INSERT_PREAMBLE && idx < 16'd8) begin
        b = (idx == 16'd7) ? 8'hD5 : 8'h55;
      end else if (idx < data_end) begin
        if (h < 16'd14)    b = hdr_q[111 - 8*int'(h) -: 8];
        else if (p < len_q) b = i_payload[PW'(p)];
        c = crc_step(c, b);
      end else if (idx < total) begin
        b = fc[8*int'(f[1:0]) +: 8];
      end
      keep_d[BYTES-1-l]          = idx < total;
      word_d[DATA_WIDTH-1-8*l -: 8] = b;
    end
    crc_d  = c;
    last_d = (cnt_q + BYTES16) >= total;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_done  = 1'b0;
    o_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start && !len_bad) state_d = SEND;
      end
      SEND: if (hs && last_q) state_d = DONE;
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word 0 is preloaded on the first SEND cycle; afterwards a new word is loaded on each
  // accept, so the counter and CRC move exactly once per handshake.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      hdr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      o_error <= 1'b0;
    end else begin
      o_error <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          if (len_bad) begin
            o_error <= 1'b1;
          end else begin
            hdr_q <= {i_dest_address, i_src_address, i_eth_type};
            len_q <= i_payload_length;
            cnt_q <= '0;
            crc_q <= CRC_INIT;
          end
        end
        SEND: if (!valid_q || hs) begin
          if (valid_q && last_q) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
          end else begin
            valid_q <= 1'b1;
            sop_q   <= cnt_q == 16'd0;
            last_q  <= last_d;
            data_q  <= word_d;
            keep_q  <= keep_d;
            cnt_q   <= cnt_q + BYTES16;
            crc_q   <= crc_d;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_frame_streamer.sv
// Bench for mac_frame_streamer: three configurations (64b PRE+FCS, 64b bare, 32b PRE+FCS)
// driven from a vector table, plus directed length-error and mid-frame reset sequences.
module tb_mac_frame_streamer;
  localparam int PMAX = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st, rdy;
  int          sel;
  logic [47:0] da, sa;
  logic [15:0] ety, plen;
  logic [7:0]  payload [PMAX];
  logic        done_a, done_b, done_c, err_a, err_b, err_c, busy_a, busy_b, busy_c;

  mac_frame_streamer_if #(.DATA_WIDTH(64)) if_a();
  mac_frame_streamer_if #(.DATA_WIDTH(64)) if_b();
  mac_frame_streamer_if #(.DATA_WIDTH(32)) if_c();

  assign if_a.i_ready = (sel == 0) && rdy;
  assign if_b.i_ready = (sel == 1) && rdy;
  assign if_c.i_ready = (sel == 2) && rdy;

  mac_frame_streamer #(.DATA_WIDTH(64), .PAYLOAD_MAX_SIZE(PMAX), .MIN_PAYLOAD(46),
                       .INSERT_PREAMBLE(1'b1), .APPEND_FCS(1'b1)) dut_a (
    .clk(clk), .i_rst(rst), .i_start(st && sel == 0), .i_dest_address(da),
    .i_src_address(sa), .i_eth_type(ety), .i_payload_length(plen), .i_payload(payload),
    .tx(if_a.master), .o_done(done_a), .o_error(err_a), .o_busy(busy_a));

  mac_frame_streamer #(.DATA_WIDTH(64), .PAYLOAD_MAX_SIZE(PMAX), .MIN_PAYLOAD(46),
                       .INSERT_PREAMBLE(1'b0), .APPEND_FCS(1'b0)) dut_b (
    .clk(clk), .i_rst(rst), .i_start(st && sel == 1), .i_dest_address(da),
    .i_src_address(sa), .i_eth_type(ety), .i_payload_length(plen), .i_payload(payload),
    .tx(if_b.master), .o_done(done_b), .o_error(err_b), .o_busy(busy_b));

  mac_frame_streamer #(.DATA_WIDTH(32), .PAYLOAD_MAX_SIZE(PMAX), .MIN_PAYLOAD(46),
                       .INSERT_PREAMBLE(1'b1), .APPEND_FCS(1'b1)) dut_c (
    .clk(clk), .i_rst(rst), .i_start(st && sel == 2), .i_dest_address(da),
    .i_src_address(sa), .i_eth_type(ety), .i_payload_length(plen), .i_payload(payload),
    .tx(if_c.master), .o_done(done_c), .o_error(err_c), .o_busy(busy_c));

  // Selected DUT, widened to 64-bit data / 8-bit keep (32b DUT sits in the low half).
  logic        cur_valid, cur_sop, cur_last, cur_done, cur_err, cur_busy;
  logic [63:0] cur_data;
  logic [7:0]  cur_keep;
  always_comb begin
    cur_valid = if_a.o_valid; cur_data = if_a.o_data; cur_keep = if_a.o_keep;
    cur_sop = if_a.o_sop; cur_last = if_a.o_last;
    cur_done = done_a; cur_err = err_a; cur_busy = busy_a;
    if (sel == 1) begin
      cur_valid = if_b.o_valid; cur_data = if_b.o_data; cur_keep = if_b.o_keep;
      cur_sop = if_b.o_sop; cur_last = if_b.o_last;
      cur_done = done_b; cur_err = err_b; cur_busy = busy_b;
    end else if (sel == 2) begin
      cur_valid = if_c.o_valid; cur_data = {32'h0, if_c.o_data}; cur_keep = {4'h0, if_c.o_keep};
      cur_sop = if_c.o_sop; cur_last = if_c.o_last;
      cur_done = done_c; cur_err = err_c; cur_busy = busy_c;
    end
  end

  typedef struct {
    int          sel;
    int          len;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] ty;
    int          rmode;      // 0: always ready, 1: toggle every cycle
    bit          stall;      // hold ready low 5 cycles on the last word
    bit          mid_start;  // pulse start while the frame is in flight
    int          exp_words;
    logic [7:0]  exp_keep;   // keep of the last word
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_d [$];
  logic [7:0]  cap_k [$];
  logic        cap_s [$];
  logic        cap_l [$];
  logic [7:0]  exp_b [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference CRC-32, one bit at a time, data bit LSB first.
  function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic build_frame(input int s, input int len);
    logic [31:0]  crc;
    logic [111:0] hdr;
    int           lp;
    exp_b.delete();
    if (s != 1) begin
      for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
      exp_b.push_back(8'hD5);
    end
    hdr = {da, sa, ety};
    for (int i = 0; i < 14; i++) exp_b.push_back(hdr[111 - 8*i -: 8]);
    lp = (len < 46) ? 46 : len;
    for (int i = 0; i < lp; i++) exp_b.push_back((i < len) ? payload[i] : 8'h00);
    if (s != 1) begin
      crc = 32'hFFFFFFFF;
      for (int i = 8; i < exp_b.size(); i++) crc = crc_bits(crc, exp_b[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) exp_b.push_back(crc[8*i +: 8]);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int          cyc, first_v, stall_n, hold_bad, nb, bad, flag_bad, idle_bad, idx;
    logic        got_last, pstall, ps, pl;
    logic [63:0] pd, wd;
    logic [7:0]  pk, eb;
    sel = v.sel; plen = 16'(v.len); da = v.da; sa = v.sa; ety = v.ty;
    cap_d.delete(); cap_k.delete(); cap_s.delete(); cap_l.delete();
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    check("busy_after_start", cur_busy, 1);
    check("valid_at_start_edge", cur_valid, 0);
    rdy = 1'b1; cyc = 0; first_v = -1; got_last = 1'b0; stall_n = 0; hold_bad = 0;
    pstall = 1'b0; pd = '0; pk = '0; ps = 1'b0; pl = 1'b0;
    while (!got_last && cyc < 400) begin
      @(negedge clk);
      if (cur_valid && first_v < 0) first_v = cyc;
      if (pstall && (!cur_valid || {cur_data, cur_keep, cur_sop, cur_last} !== {pd, pk, ps, pl}))
        hold_bad++;
      pstall = cur_valid && !rdy;
      pd = cur_data; pk = cur_keep; ps = cur_sop; pl = cur_last;
      if (cur_valid && rdy) begin
        cap_d.push_back(cur_data); cap_k.push_back(cur_keep);
        cap_s.push_back(cur_sop);  cap_l.push_back(cur_last);
        got_last = cur_last;
      end
      st = (v.mid_start && cyc == 4);
      @(posedge clk); #1;
      if (v.stall && cur_valid && cur_last && stall_n < 5) begin
        rdy = 1'b0; stall_n++;
      end else if (v.rmode == 1) rdy = ~rdy;
      else rdy = 1'b1;
      cyc++;
    end
    st = 1'b0;
    check("frame_completed", got_last, 1);
    check("done_pulse", cur_done, 1);
    check("valid_drop_after_last", cur_valid, 0);
    @(posedge clk); #1;
    check("done_clear", cur_done, 0);
    check("busy_clear", cur_busy, 0);
    if (v.mid_start) begin
      idle_bad = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (cur_valid || cur_busy) idle_bad++;
      end
      check("start_while_busy_ignored", idle_bad, 0);
    end
    check("first_word_latency", first_v, 1);
    check("hold_while_stalled", hold_bad, 0);
    if (v.stall) check("stall_cycles", stall_n, 5);
    check("word_count", cap_d.size(), v.exp_words);
    if (cap_k.size() > 0) check("last_keep", cap_k[cap_k.size()-1], v.exp_keep);
    build_frame(v.sel, v.len);
    nb = (v.sel == 2) ? 4 : 8;
    bad = 0; flag_bad = 0;
    for (int w = 0; w < cap_d.size(); w++) begin
      wd = cap_d[w];
      for (int l = 0; l < nb; l++) begin
        idx = w*nb + l;
        eb  = (idx < exp_b.size()) ? exp_b[idx] : 8'h00;
        if (wd[8*(nb-1-l) +: 8] !== eb) bad++;
        if (cap_k[w][nb-1-l] !== (idx < exp_b.size())) flag_bad++;
      end
      if (cap_s[w] !== (w == 0)) flag_bad++;
      if (cap_l[w] !== (w == cap_d.size()-1)) flag_bad++;
    end
    check("frame_bytes", bad, 0);
    check("sop_last_keep_flags", flag_bad, 0);
  endtask

  vec_t vt [8];

  initial begin
    vt[0] = '{0,  6, 48'hFFFFFFFFFFFF, 48'h112233445566, 16'h0800, 0, 1'b0, 1'b0,  9, 8'hFF};
    vt[1] = '{1, 47, 48'h0A0B0C0D0E0F, 48'h102030405060, 16'h88B5, 0, 1'b0, 1'b0,  8, 8'hF8};
    vt[2] = '{0,  6, 48'hFFFFFFFFFFFF, 48'h112233445566, 16'h0800, 1, 1'b1, 1'b0,  9, 8'hFF};
    vt[3] = '{2,  0, 48'h010203040506, 48'hA1A2A3A4A5A6, 16'h0806, 0, 1'b0, 1'b0, 18, 8'h0F};
    vt[4] = '{0, 64, 48'h00AABBCCDDEE, 48'h0200000000FE, 16'h86DD, 0, 1'b0, 1'b0, 12, 8'hC0};
    vt[5] = '{1, 50, 48'hFEDCBA987654, 48'h13579BDF0246, 16'h0800, 1, 1'b0, 1'b0,  8, 8'hFF};
    vt[6] = '{2, 47, 48'h5A5A5A5A5A5A, 48'hC3C3C3C3C3C3, 16'h0801, 1, 1'b1, 1'b0, 19, 8'h08};
    vt[7] = '{0, 45, 48'h010000000001, 48'h020000000002, 16'h0800, 0, 1'b0, 1'b1,  9, 8'hFF};

    for (int i = 0; i < PMAX; i++) payload[i] = 8'(i*37 + 11);
    payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE;
    payload[3] = 8'hEF; payload[4] = 8'h12; payload[5] = 8'h34;

    rst = 1'b1; st = 1'b0; rdy = 1'b0; sel = 0;
    da = '0; sa = '0; ety = '0; plen = '0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("reset_valid", cur_valid, 0);
      check("reset_data", cur_data, 0);
      check("reset_ctl", {cur_keep, cur_sop, cur_last, cur_done, cur_err, cur_busy}, 0);
    end
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(vt[i]);
      if (i == 0 && cap_d.size() >= 4) begin
        check("t1_w0", cap_d[0], 64'h55555555555555D5);
        check("t1_w1", cap_d[1], 64'hFFFFFFFFFFFF1122);
        check("t1_w2", cap_d[2], 64'h334455660800DEAD);
        check("t1_w3", cap_d[3], 64'hBEEF123400000000);
      end
    end

    // Over-length start: error pulse, no frame.
    sel = 0; plen = 16'(PMAX + 1);
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    check("len_err_pulse", cur_err, 1);
    check("len_err_valid", cur_valid, 0);
    check("len_err_busy", cur_busy, 0);
    @(posedge clk); #1;
    check("len_err_clear", cur_err, 0);
    check("len_err_still_idle", {cur_valid, cur_busy}, 0);

    // Reset while word 3 is on the bus.
    sel = 0; plen = 16'd6; da = vt[0].da; sa = vt[0].sa; ety = vt[0].ty; rdy = 1'b1;
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_mid_w3", cur_data, 64'hBEEF123400000000);
    rst = 1'b1; #1;
    check("abort_valid", cur_valid, 0);
    check("abort_data", cur_data, 0);
    check("abort_ctl", {cur_keep, cur_sop, cur_last, cur_done, cur_err, cur_busy}, 0);
    @(posedge clk); #1;
    check("abort_no_done", cur_done, 0);
    @(negedge clk); rst = 1'b0;
    run_frame(vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
